core_seq_ctrl: RTL and testbench
================================

# core_seq_ctrl

Hardware instruction sequencer for the systolic core: it generates, cycle by cycle, the 34-bit `inst` bus for one full convolution layer. That covers kernel fetch/load, activation fetch, execution, OFIFO drain to psum memory and final accumulation, over all kernel positions. It supports both weight-stationary and output-stationary dataflow and is parametrised in array size and image/kernel geometry. It sits between the host/top level and `core`, replacing bench-driven instruction streams.

## Interface
- `ROW`, 8: PE array rows.
- `COL`, 8: PE array columns; also the number of kernel words per kij.
- `IN_W`, 6: input image width; len_nij = IN_W².
- `K_W`, 3: kernel width; len_kij = K_W²; OUT_W = IN_W−K_W+1; len_onij = OUT_W².
- `ADDR_W`, 11: xmem/pmem address width.
- `KMEM_BASE`, 1024: xmem base address of kernel words.
- `GAP`, 10: idle cycles between kernel load and activation fetch.
- `clk`  input  1  clock, rising edge.
- `reset`  input  1  asynchronous, active-low (0 = reset).
- `start`  input  1  one-cycle pulse; begins a layer when idle.
- `mode`  input  2  mode[1]: 0 = WS, 1 = OS; mode[0]: precision, passed to core untouched. Sampled on accepted `start`.
- `ofifo_valid`  input  1  from core; OFIFO holds a full result set.
- `inst`  output  34  bit map: [33] acc, [32] CEN_pmem, [31] WEN_pmem, [30:20] A_pmem, [19] CEN_xmem, [18] WEN_xmem, [17:7] A_xmem, [6] ofifo_rd, [5] ififo_wr, [4] ififo_rd, [3] l0_rd, [2] l0_wr, [1] execute, [0] load.
- `acc_clr`  output  1  one-cycle pulse clearing the SFP accumulator before each output pixel.
- `out_strobe`  output  1  one-cycle pulse when `sfp_out` holds a finished output pixel.
- `kij`  output  ceil(log2(len_kij))  current kernel position.
- `busy`  output  1  high outside IDLE.
- `done`  output  1  one-cycle pulse on completion.

## Operation
- IDLE inst value: CEN/WEN bits = 1, all others 0, addresses 0 (34'h1_800C_0000). This is also the reset value. All other outputs reset to 0.
- States: IDLE → W_RD → W_LOAD → GAP_W → A_RD → EXEC → OF_WAIT → OF_RD → (kij < len_kij−1 ? W_RD : ACC) → IDLE.
- W_RD, COL+1 cycles:
  - xmem read (CEN=0, WEN=1) at KMEM_BASE+kij·COL+t for t<COL.
  - Write strobe in cycles 1..COL: l0_wr (WS) or ififo_wr (OS).
- W_LOAD, COL cycles: load=1 with l0_rd (WS) or ififo_rd (OS).
- GAP_W: GAP cycles, idle inst.
- A_RD, len_nij+1 cycles: xmem read at address t for t<len_nij; l0_wr in cycles 1..len_nij.
- EXEC, len_nij+ROW+COL cycles: execute=1 and l0_rd=1 for the first len_nij cycles, 0 afterwards.
- OF_WAIT: hold idle until ofifo_valid=1. No timeout.
- OF_RD, len_nij+1 cycles:
  - ofifo_rd=1 for t<len_nij.
  - pmem write (CEN=0, WEN=0) at kij·(len_nij+1)+(t−1) for t in 1..len_nij.
- ACC, per output o in 0..len_onij−1:
  - Pulse acc_clr.
  - Then len_kij pmem reads (CEN=0, WEN=1) at k·(len_nij+1) + ((o/OUT_W + k/K_W)·IN_W + o%OUT_W + k%K_W), for k = 0..len_kij−1.
  - acc=1 in the cycle after each read.
  - out_strobe one cycle after the last acc.
- After the final out_strobe, pulse done and return to IDLE.
- `start` while busy is ignored. `mode` changes while busy have no effect.
- All address arithmetic is computed at ADDR_W bits; overflow wraps.

## Timing
- `inst` is registered: a command appears one cycle after the state/counter that produces it.
- `start` in cycle n → first W_RD command on `inst` in cycle n+2.
- Per-kij cycles excluding OF_WAIT: (COL+1)+COL+GAP+(len_nij+1)+(len_nij+ROW+COL)+(len_nij+1). Defaults: 9+8+10+37+52+37 = 153.
- ACC per output: 1 + len_kij + 2 = 12 cycles.
- Reset asserted mid-operation: immediate return to IDLE with idle inst. No partial pulses follow deassertion.
- ofifo_valid is sampled only in OF_WAIT.

## Structure
- Shared package `core_pkg`:
  - inst bit-position constants;
  - `IDLE_INST`;
  - the WS/OS and BIT4/BIT2 mode encodings;
  - the state enum.
- One sub-module `seq_addr_gen`: combinational pmem accumulation-address generator, taking (o, k) → A_pmem via div/mod by OUT_W and K_W. All remaining logic lives in the top FSM plus counters.

## Test plan
- Reset held, then released with no start → inst = 34'h1_800C_0000; busy, done, acc_clr and out_strobe all 0.
- WS, start at cycle 0:
  - 8 xmem reads at 1024..1031 followed by 8 l0_wr pulses;
  - next, 8 cycles of load=1 with l0_rd=1;
  - ififo_wr and ififo_rd stay 0 throughout.
- OS, start → same sequence, but ififo_wr/ififo_rd replace l0_wr/l0_rd; l0_wr is used only in A_RD.
- ofifo_valid held low for 20 cycles after EXEC → FSM stalls in OF_WAIT with idle inst. On rising ofifo_valid, OF_RD writes pmem 0..35 for kij=0 and 37..72 for kij=1.
- Accumulation, o=5, k=4 → A_pmem = 162. Bench also checks o=0, k=8 → 310, and that out_strobe fires 16 times, then done fires once.
- Reset asserted in EXEC during kij=3 → next cycle is idle inst, busy=0, kij=0. A new start restarts from kij=0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared definitions for the systolic-core instruction sequencer: inst bus
// bit positions, the idle instruction word, mode encodings and FSM states.
package core_pkg;

    localparam int INST_W        = 34;
    localparam int INST_ACC      = 33;
    localparam int INST_CEN_PMEM = 32;
    localparam int INST_WEN_PMEM = 31;
    localparam int INST_A_PMEM   = 20;   // LSB of the pmem address field
    localparam int INST_CEN_XMEM = 19;
    localparam int INST_WEN_XMEM = 18;
    localparam int INST_A_XMEM   = 7;    // LSB of the xmem address field
    localparam int INST_OFIFO_RD = 6;
    localparam int INST_IFIFO_WR = 5;
    localparam int INST_IFIFO_RD = 4;
    localparam int INST_L0_RD    = 3;
    localparam int INST_L0_WR    = 2;
    localparam int INST_EXECUTE  = 1;
    localparam int INST_LOAD     = 0;

    // Both memories deselected and write-disabled, everything else quiet.
    localparam logic [INST_W-1:0] IDLE_INST = 34'h1_800C_0000;

    // mode[1]: dataflow, mode[0]: precision (consumed by core directly).
    localparam logic MODE_WS   = 1'b0;
    localparam logic MODE_OS   = 1'b1;
    localparam logic PREC_BIT4 = 1'b0;
    localparam logic PREC_BIT2 = 1'b1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_RD,
        S_W_LOAD,
        S_GAP_W,
        S_A_RD,
        S_EXEC,
        S_OF_WAIT,
        S_OF_RD,
        S_ACC
    } state_t;

endpackage

// File: rtl/seq_addr_gen.sv
// Accumulation address generator: maps (output pixel o, kernel position k)
// to the pmem word holding that pixel's partial sum for kernel position k.
// Each kij owns a pmem slab of len_nij+1 words.
module seq_addr_gen
    import core_pkg::*;
#(
    parameter int IN_W    = 6,
    parameter int K_W     = 3,
    parameter int ADDR_W  = 11,
    parameter int O_W     = 4,
    parameter int K_IDX_W = 4
) (
    input  logic [O_W-1:0]     o,
    input  logic [K_IDX_W-1:0] k,
    output logic [ADDR_W-1:0]  addr
);

    localparam int OUT_W   = IN_W - K_W + 1;
    localparam int LEN_NIJ = IN_W * IN_W;

    logic [31:0] o_w;
    logic [31:0] k_w;
    logic [31:0] o_row;
    logic [31:0] o_col;
    logic [31:0] k_row;
    logic [31:0] k_col;
    logic [31:0] sum;

    // Split o and k into 2-D coordinates and locate the input pixel in slab k.
    always_comb begin
        o_w   = 32'(o);
        k_w   = 32'(k);
        o_row = o_w / 32'(OUT_W);
        o_col = o_w % 32'(OUT_W);
        k_row = k_w / 32'(K_W);
        k_col = k_w % 32'(K_W);
        sum   = k_w * 32'(LEN_NIJ + 1)
              + (o_row + k_row) * 32'(IN_W)
              + o_col + k_col;
    end

    assign addr = ADDR_W'(sum);

endmodule

// File: rtl/core_seq_ctrl.sv
// Instruction sequencer for one convolution layer on the systolic core.
// Per kernel position: weight fetch/load, activation fetch, execute, OFIFO
// drain to pmem; afterwards accumulate every output pixel from pmem.
module core_seq_ctrl
    import core_pkg::*;
#(
    parameter int ROW       = 8,
    parameter int COL       = 8,
    parameter int IN_W      = 6,
    parameter int K_W       = 3,
    parameter int ADDR_W    = 11,
    parameter int KMEM_BASE = 1024,
    parameter int GAP       = 10,
    parameter int KIJ_W     = (K_W * K_W > 1) ? $clog2(K_W * K_W) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst,
    output logic              acc_clr,
    output logic              out_strobe,
    output logic [KIJ_W-1:0]  kij,
    output logic              busy,
    output logic              done
);

    localparam int LEN_NIJ  = IN_W * IN_W;
    localparam int LEN_KIJ  = K_W * K_W;
    localparam int OUT_W    = IN_W - K_W + 1;
    localparam int LEN_ONIJ = OUT_W * OUT_W;
    localparam int O_W      = (LEN_ONIJ > 1) ? $clog2(LEN_ONIJ) : 1;
    localparam int T_W      = 16;
    localparam int EXEC_LEN = LEN_NIJ + ROW + COL;

    localparam logic [T_W-1:0] T_ZERO      = '0;
    localparam logic [T_W-1:0] T_ONE       = T_W'(1);
    localparam logic [T_W-1:0] T_COL       = T_W'(COL);
    localparam logic [T_W-1:0] T_COL_LAST  = T_W'(COL - 1);
    localparam logic [T_W-1:0] T_GAP_LAST  = T_W'(GAP - 1);
    localparam logic [T_W-1:0] T_NIJ       = T_W'(LEN_NIJ);
    localparam logic [T_W-1:0] T_EXEC_LAST = T_W'(EXEC_LEN - 1);
    localparam logic [T_W-1:0] T_ACC_FIRST = T_W'(2);
    localparam logic [T_W-1:0] T_KIJ       = T_W'(LEN_KIJ);
    localparam logic [T_W-1:0] T_KIJ_P1    = T_W'(LEN_KIJ + 1);
    localparam logic [T_W-1:0] T_STROBE    = T_W'(LEN_KIJ + 2);
    localparam logic [T_W-1:0] T_DONE      = T_W'(LEN_KIJ + 3);
    localparam logic [KIJ_W-1:0] KIJ_LAST  = KIJ_W'(LEN_KIJ - 1);
    localparam logic [O_W-1:0]   O_LAST    = O_W'(LEN_ONIJ - 1);

    state_t              state_reg, state_next;
    logic [T_W-1:0]      t_reg, t_next;
    logic [KIJ_W-1:0]    kij_reg, kij_next;
    logic [O_W-1:0]      o_reg, o_next;
    logic                os_reg, os_next;
    logic [INST_W-1:0]   inst_reg, inst_next;
    logic                acc_clr_reg, acc_clr_next;
    logic                out_strobe_reg, out_strobe_next;
    logic                done_reg, done_next;

    logic [ADDR_W-1:0]   kmem_addr;
    logic [ADDR_W-1:0]   act_addr;
    logic [ADDR_W-1:0]   psum_wr_addr;
    logic [ADDR_W-1:0]   acc_addr;
    logic [KIJ_W-1:0]    acc_k;
    logic                unused_ok;

    // Precision bit is forwarded to core outside this block.
    assign unused_ok = &{1'b0, mode[0], PREC_BIT4, PREC_BIT2};

    assign kmem_addr    = ADDR_W'(KMEM_BASE) + ADDR_W'(kij_reg) * ADDR_W'(COL) + ADDR_W'(t_reg);
    assign act_addr     = ADDR_W'(t_reg);
    assign psum_wr_addr = ADDR_W'(kij_reg) * ADDR_W'(LEN_NIJ + 1) + ADDR_W'(t_reg) - ADDR_W'(1);
    assign acc_k        = KIJ_W'(t_reg - T_ONE);

    seq_addr_gen #(
        .IN_W    (IN_W),
        .K_W     (K_W),
        .ADDR_W  (ADDR_W),
        .O_W     (O_W),
        .K_IDX_W (KIJ_W)
    ) u_addr_gen (
        .o    (o_reg),
        .k    (acc_k),
        .addr (acc_addr)
    );

    // State, counters and registered command outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg      <= S_IDLE;
            t_reg          <= '0;
            kij_reg        <= '0;
            o_reg          <= '0;
            os_reg         <= MODE_WS;
            inst_reg       <= IDLE_INST;
            acc_clr_reg    <= 1'b0;
            out_strobe_reg <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            t_reg          <= t_next;
            kij_reg        <= kij_next;
            o_reg          <= o_next;
            os_reg         <= os_next;
            inst_reg       <= inst_next;
            acc_clr_reg    <= acc_clr_next;
            out_strobe_reg <= out_strobe_next;
            done_reg       <= done_next;
        end
    end

    // Next state and the command word produced by the current state/counter.
    always_comb begin
        state_next      = state_reg;
        t_next          = t_reg + T_ONE;
        kij_next        = kij_reg;
        o_next          = o_reg;
        os_next         = os_reg;
        inst_next       = IDLE_INST;
        acc_clr_next    = 1'b0;
        out_strobe_next = 1'b0;
        done_next       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                t_next = T_ZERO;
                if (start) begin
                    state_next = S_W_RD;
                    kij_next   = '0;
                    o_next     = '0;
                    os_next    = (mode[1] == MODE_OS);
                end
            end

            S_W_RD: begin
                if (t_reg < T_COL) begin
                    inst_next[INST_CEN_XMEM] = 1'b0;
                    inst_next[INST_A_XMEM +: ADDR_W] = kmem_addr;
                end
                if (t_reg != T_ZERO) begin
                    if (os_reg) inst_next[INST_IFIFO_WR] = 1'b1;
                    else        inst_next[INST_L0_WR]    = 1'b1;
                end
                if (t_reg == T_COL) begin
                    state_next = S_W_LOAD;
                    t_next     = T_ZERO;
                end
            end

            S_W_LOAD: begin
                inst_next[INST_LOAD] = 1'b1;
                if (os_reg) inst_next[INST_IFIFO_RD] = 1'b1;
                else        inst_next[INST_L0_RD]    = 1'b1;
                if (t_reg == T_COL_LAST) begin
                    state_next = S_GAP_W;
                    t_next     = T_ZERO;
                end
            end

            S_GAP_W: begin
                if (t_reg == T_GAP_LAST) begin
                    state_next = S_A_RD;
                    t_next     = T_ZERO;
                end
            end

            S_A_RD: begin
                if (t_reg < T_NIJ) begin
                    inst_next[INST_CEN_XMEM] = 1'b0;
                    inst_next[INST_A_XMEM +: ADDR_W] = act_addr;
                end
                if (t_reg != T_ZERO) inst_next[INST_L0_WR] = 1'b1;
                if (t_reg == T_NIJ) begin
                    state_next = S_EXEC;
                    t_next     = T_ZERO;
                end
            end

            S_EXEC: begin
                if (t_reg < T_NIJ) begin
                    inst_next[INST_EXECUTE] = 1'b1;
                    inst_next[INST_L0_RD]   = 1'b1;
                end
                if (t_reg == T_EXEC_LAST) begin
                    state_next = S_OF_WAIT;
                    t_next     = T_ZERO;
                end
            end

            S_OF_WAIT: begin
                t_next = T_ZERO;
                if (ofifo_valid) state_next = S_OF_RD;
            end

            S_OF_RD: begin
                if (t_reg < T_NIJ) inst_next[INST_OFIFO_RD] = 1'b1;
                if (t_reg != T_ZERO) begin
                    inst_next[INST_CEN_PMEM] = 1'b0;
                    inst_next[INST_WEN_PMEM] = 1'b0;
                    inst_next[INST_A_PMEM +: ADDR_W] = psum_wr_addr;
                end
                if (t_reg == T_NIJ) begin
                    t_next = T_ZERO;
                    if (kij_reg == KIJ_LAST) begin
                        state_next = S_ACC;
                        o_next     = '0;
                    end else begin
                        state_next = S_W_RD;
                        kij_next   = kij_reg + KIJ_W'(1);
                    end
                end
            end

            S_ACC: begin
                if (t_reg == T_ZERO) acc_clr_next = 1'b1;
                if (t_reg != T_ZERO && t_reg <= T_KIJ) begin
                    inst_next[INST_CEN_PMEM] = 1'b0;
                    inst_next[INST_A_PMEM +: ADDR_W] = acc_addr;
                end
                if (t_reg >= T_ACC_FIRST && t_reg <= T_KIJ_P1) inst_next[INST_ACC] = 1'b1;
                if (t_reg == T_STROBE) begin
                    out_strobe_next = 1'b1;
                    if (o_reg != O_LAST) begin
                        o_next = o_reg + O_W'(1);
                        t_next = T_ZERO;
                    end
                end
                if (t_reg == T_DONE) begin
                    done_next  = 1'b1;
                    state_next = S_IDLE;
                    kij_next   = '0;
                    t_next     = T_ZERO;
                end
            end

            default: begin
                state_next = S_IDLE;
                t_next     = T_ZERO;
            end
        endcase
    end

    assign inst       = inst_reg;
    assign acc_clr    = acc_clr_reg;
    assign out_strobe = out_strobe_reg;
    assign done       = done_reg;
    assign kij        = kij_reg;
    assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Directed bench for core_seq_ctrl with default geometry (8x8 array,
// 6x6 image, 3x3 kernel).
module tb_core_seq_ctrl;

    localparam logic [33:0] IDLE_I = 34'h1_800C_0000;
    localparam logic [33:0] B_LOAD = 34'h1;
    localparam logic [33:0] B_EXEC = 34'h2;
    localparam logic [33:0] B_L0WR = 34'h4;
    localparam logic [33:0] B_L0RD = 34'h8;
    localparam logic [33:0] B_IFRD = 34'h10;
    localparam logic [33:0] B_IFWR = 34'h20;
    localparam logic [33:0] B_OFRD = 34'h40;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic        ofifo_valid = 1'b0;
    logic [33:0] inst;
    logic        acc_clr;
    logic        out_strobe;
    logic [3:0]  kij;
    logic        busy;
    logic        done;

    always #5 clk = ~clk;

    core_seq_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .mode        (mode),
        .ofifo_valid (ofifo_valid),
        .inst        (inst),
        .acc_clr     (acc_clr),
        .out_strobe  (out_strobe),
        .kij         (kij),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        string       name;
        int          g;
        logic [33:0] exp_ws;
        logic [33:0] exp_os;
    } vec_t;

    vec_t        vecs [15];
    logic [33:0] cap [0:135];
    logic [10:0] wr_q [$];
    logic [10:0] rd_q [$];
    int n_assert = 0;
    int n_fail   = 0;
    int acc_cnt, clr_cnt, strobe_cnt, done_cnt, strobe_after_acc, done_after_strobe;
    logic prev_acc, prev_strobe;

    function automatic logic [33:0] xrd(input int a);
        return (IDLE_I & ~(34'd1 << 19)) | (34'(a) << 7);
    endfunction

    function automatic logic [33:0] pwr(input int a);
        return (IDLE_I & ~(34'd1 << 32) & ~(34'd1 << 31)) | (34'(a) << 20);
    endfunction

    task automatic check(input string name, input logic [33:0] act, input logic [33:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic clear_mon();
        wr_q.delete();
        rd_q.delete();
        acc_cnt = 0; clr_cnt = 0; strobe_cnt = 0; done_cnt = 0;
        strobe_after_acc = 0; done_after_strobe = 0;
        prev_acc = 1'b0; prev_strobe = 1'b0;
    endtask

    // Advance to the next falling edge and log pmem traffic and pulses.
    task automatic step();
        @(negedge clk);
        if (!inst[32] && !inst[31]) wr_q.push_back(inst[30:20]);
        if (!inst[32] &&  inst[31]) rd_q.push_back(inst[30:20]);
        if (inst[33]) acc_cnt++;
        if (acc_clr) clr_cnt++;
        if (out_strobe) begin
            strobe_cnt++;
            if (prev_acc) strobe_after_acc++;
        end
        if (done) begin
            done_cnt++;
            if (prev_strobe) done_after_strobe++;
        end
        prev_acc    = inst[33];
        prev_strobe = out_strobe;
    endtask

    // Compare the FIFO/L0 strobe bits of one captured kij against the schedule.
    task automatic strobe_map(input logic os, input string name);
        int errs = 0;
        for (int g = 0; g < 116; g++) begin
            logic w_wr, w_rd, a_wr, a_rd;
            w_wr = (g >= 1 && g <= 8);
            w_rd = (g >= 9 && g <= 16);
            a_wr = (g >= 28 && g <= 63);
            a_rd = (g >= 64 && g <= 99);
            if (cap[g][2] !== (a_wr | (!os & w_wr))) errs++;
            if (cap[g][3] !== (a_rd | (!os & w_rd))) errs++;
            if (cap[g][5] !== (os & w_wr)) errs++;
            if (cap[g][4] !== (os & w_rd)) errs++;
        end
        check(name, 34'(errs), 34'd0);
    endtask

    initial begin
        int   stall_bad;
        logic found;
        logic quiet_bad;

        vecs[0]  = '{"wrd0",     0,   xrd(1024),                 xrd(1024)};
        vecs[1]  = '{"wrd1",     1,   xrd(1025) | B_L0WR,        xrd(1025) | B_IFWR};
        vecs[2]  = '{"wrd7",     7,   xrd(1031) | B_L0WR,        xrd(1031) | B_IFWR};
        vecs[3]  = '{"wrd_tail", 8,   IDLE_I | B_L0WR,           IDLE_I | B_IFWR};
        vecs[4]  = '{"wload0",   9,   IDLE_I | B_LOAD | B_L0RD,  IDLE_I | B_LOAD | B_IFRD};
        vecs[5]  = '{"wload7",   16,  IDLE_I | B_LOAD | B_L0RD,  IDLE_I | B_LOAD | B_IFRD};
        vecs[6]  = '{"gap0",     17,  IDLE_I,                    IDLE_I};
        vecs[7]  = '{"gap9",     26,  IDLE_I,                    IDLE_I};
        vecs[8]  = '{"ard0",     27,  xrd(0),                    xrd(0)};
        vecs[9]  = '{"ard35",    62,  xrd(35) | B_L0WR,          xrd(35) | B_L0WR};
        vecs[10] = '{"ard_tail", 63,  IDLE_I | B_L0WR,           IDLE_I | B_L0WR};
        vecs[11] = '{"exec0",    64,  IDLE_I | B_EXEC | B_L0RD,  IDLE_I | B_EXEC | B_L0RD};
        vecs[12] = '{"exec35",   99,  IDLE_I | B_EXEC | B_L0RD,  IDLE_I | B_EXEC | B_L0RD};
        vecs[13] = '{"drain0",   100, IDLE_I,                    IDLE_I};
        vecs[14] = '{"drain15",  115, IDLE_I,                    IDLE_I};

        clear_mon();
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
        check("rst_inst",       inst,              IDLE_I);
        check("rst_busy",       34'(busy),         34'd0);
        check("rst_done",       34'(done),         34'd0);
        check("rst_acc_clr",    34'(acc_clr),      34'd0);
        check("rst_out_strobe", 34'(out_strobe),   34'd0);

        // ---- WS layer, full run ----
        clear_mon();
        mode  = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        mode  = 2'b11;                      // must not affect the running layer
        check("busy_on", 34'(busy), 34'd1);
        stall_bad = 0;
        for (int g = 0; g < 136; g++) begin
            step();
            cap[g] = inst;
            start = (g == 50);              // ignored while busy
            if (g == 0) check("kij_first", 34'(kij), 34'd0);
            if (g >= 116 && (inst !== IDLE_I || busy !== 1'b1)) stall_bad++;
        end
        start = 1'b0;
        for (int i = 0; i < 15; i++) check({vecs[i].name, "_ws"}, cap[vecs[i].g], vecs[i].exp_ws);
        strobe_map(1'b0, "ws_strobe_map");
        check("of_wait_stall", 34'(stall_bad), 34'd0);

        ofifo_valid = 1'b1;
        step();
        check("of_wait_last", inst, IDLE_I);
        step();
        check("ofrd_t0", inst, IDLE_I | B_OFRD);
        step();
        check("ofrd_t1", inst, pwr(0) | B_OFRD);

        for (int c = 0; c < 4000 && done_cnt == 0; c++) step();
        repeat (5) step();
        check("done_seen", 34'(done_cnt), 34'd1);
        check("done_after_strobe", 34'(done_after_strobe), 34'd1);
        check("idle_after_done", inst, IDLE_I);
        check("busy_after_done", 34'(busy), 34'd0);
        check("pmem_wr_count", 34'(wr_q.size()), 34'd324);
        begin
            int bad0 = 0, bad1 = 0;
            for (int i = 0; i < 36 && i < wr_q.size(); i++)
                if (wr_q[i] !== 11'(i)) bad0++;
            for (int i = 36; i < 72 && i < wr_q.size(); i++)
                if (wr_q[i] !== 11'(i + 1)) bad1++;
            check("pmem_wr_kij0", 34'(bad0), 34'd0);
            check("pmem_wr_kij1", 34'(bad1), 34'd0);
        end
        check("pmem_rd_count", 34'(rd_q.size()), 34'd144);
        if (rd_q.size() == 144) begin
            check("acc_addr_o5_k4", 34'(rd_q[5 * 9 + 4]), 34'd162);
            check("acc_addr_o0_k8", 34'(rd_q[0 * 9 + 8]), 34'd310);
        end
        check("acc_count",        34'(acc_cnt),          34'd144);
        check("acc_clr_count",    34'(clr_cnt),          34'd16);
        check("out_strobe_count", 34'(strobe_cnt),       34'd16);
        check("strobe_after_acc", 34'(strobe_after_acc), 34'd16);

        // ---- OS layer, aborted by reset in EXEC of kij=3 ----
        clear_mon();
        mode  = 2'b10;
        start = 1'b1;
        step();
        start = 1'b0;
        mode  = 2'b00;
        for (int g = 0; g < 116; g++) begin
            step();
            cap[g] = inst;
        end
        for (int i = 0; i < 15; i++) check({vecs[i].name, "_os"}, cap[vecs[i].g], vecs[i].exp_os);
        strobe_map(1'b1, "os_strobe_map");

        found = 1'b0;
        for (int c = 0; c < 3000 && !found; c++) begin
            step();
            if (kij == 4'd3 && inst[1]) found = 1'b1;
        end
        check("kij3_exec_seen", 34'(found), 34'd1);
        reset = 1'b0;
        step();
        check("abort_inst", inst,       IDLE_I);
        check("abort_busy", 34'(busy),  34'd0);
        check("abort_kij",  34'(kij),   34'd0);
        reset = 1'b1;
        quiet_bad = 1'b0;
        repeat (4) begin
            step();
            if (acc_clr || out_strobe || done || busy || inst !== IDLE_I) quiet_bad = 1'b1;
        end
        check("post_reset_quiet", 34'(quiet_bad), 34'd0);

        mode  = 2'b00;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        check("restart_wrd0", inst,      xrd(1024));
        check("restart_kij",  34'(kij),  34'd0);
        step();
        check("restart_wrd1", inst,      xrd(1025) | B_L0WR);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
